// File: rtl/aixh_mxc_drain_packer_pkg.sv
// Shared types and default element widths for the MXC drain packer.
package AIXH_MXC_pkg;

    localparam int ACCUM_BITS = 48;
    localparam int SCALE_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic [SCALE_BITS-1:0] scale;
        logic [ACCUM_BITS-1:0] acc;
    } drain_elem_t;

endpackage

// File: rtl/aixh_mxc_drain_packer_requant.sv
// Three-stage requantisation pipe: scale, round-and-shift, saturate to INT8.
module aixh_mxc_drain_requant #(
    parameter int ACC_W = 48,
    parameter int SCL_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [5:0]       shift,
    input  logic             relu,
    input  logic             in_vld,
    input  logic [ACC_W-1:0] in_acc,
    input  logic [SCL_W-1:0] in_scale,
    output logic             out_vld,
    output logic [7:0]       out_q
);

    logic signed [63:0] prod_s;
    logic signed [63:0] p1_r;
    logic signed [64:0] rnd_s;
    logic signed [64:0] sum_s;
    logic signed [64:0] p2_s;
    logic signed [64:0] p2_r;
    logic [7:0]         q3_s;
    logic [7:0]         q3_r;
    logic               vld1_r;
    logic               vld2_r;
    logic               vld3_r;

    // Datapath for all three stages; the sum is one bit wider so rounding cannot wrap.
    always_comb begin
        prod_s = $signed({{(64-ACC_W){in_acc[ACC_W-1]}}, in_acc})
               * $signed({{(64-SCL_W){1'b0}}, in_scale});
        rnd_s  = 65'sd0;
        if (shift != 6'd0) begin
            rnd_s = 65'sd1 <<< (shift - 6'd1);
        end else begin
            rnd_s = 65'sd0;
        end
        sum_s = $signed({p1_r[63], p1_r}) + rnd_s;
        p2_s  = sum_s >>> shift;
        q3_s  = 8'h00;
        if (relu) begin
            if (p2_r < 65'sd0) begin
                q3_s = 8'h00;
            end else if (p2_r > 65'sd127) begin
                q3_s = 8'h7F;
            end else begin
                q3_s = p2_r[7:0];
            end
        end else begin
            if (p2_r > 65'sd127) begin
                q3_s = 8'h7F;
            end else if (p2_r < -65'sd128) begin
                q3_s = 8'h80;
            end else begin
                q3_s = p2_r[7:0];
            end
        end
    end

    // Pipe registers; the pipe never stalls and valid tags ride alongside the data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            p1_r   <= 64'sd0;
            p2_r   <= 65'sd0;
            q3_r   <= 8'h00;
            vld1_r <= 1'b0;
            vld2_r <= 1'b0;
            vld3_r <= 1'b0;
        end else begin
            p1_r   <= prod_s;
            p2_r   <= p2_s;
            q3_r   <= q3_s;
            vld1_r <= in_vld;
            vld2_r <= vld1_r;
            vld3_r <= vld2_r;
        end
    end

    assign out_vld = vld3_r;
    assign out_q   = q3_r;

endmodule

// File: rtl/aixh_mxc_drain_packer.sv
// Drain packer: requantises the drained row stream to INT8, packs LANES per word
// and writes the words to one LTC slice at linearly increasing addresses.
module aixh_mxc_drain_packer
    import AIXH_MXC_pkg::*;
#(
    parameter int LTC_DWIDTH = 256,
    parameter int LTC_AWIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          aixh_core_clk2x,
    input  logic                          aixh_core_rstn,
    input  logic                          cfg_start,
    input  logic [LTC_AWIDTH-1:0]         cfg_base,
    input  logic [15:0]                   cfg_words,
    input  logic [5:0]                    cfg_shift,
    input  logic                          cfg_relu,
    input  logic                          i_vld,
    input  logic [SCALE_BITS+ACCUM_BITS-1:0] i_dat,
    output logic                          ltc_awvalid,
    output logic [LTC_AWIDTH-1:0]         ltc_awaddr,
    output logic [LTC_DWIDTH-1:0]         ltc_wdata,
    input  logic                          ltc_awupdate,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err
);

    localparam int LANES  = LTC_DWIDTH / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ECNT_W = 16 + LANE_W + 1;

    drain_state_t          state_r, state_s;
    drain_elem_t           elem_s;
    logic [15:0]           words_r;
    logic [15:0]           done_cnt_r;
    logic [5:0]            shift_r;
    logic                  relu_r;
    logic [ECNT_W-1:0]     elem_cnt_r;
    logic [ECNT_W-1:0]     elem_inc_s;
    logic [ECNT_W-1:0]     quota_s;
    logic [LANE_W-1:0]     lane_r;
    logic [LTC_DWIDTH-1:0] word_r;
    logic [LTC_DWIDTH-1:0] push_word_s;
    logic [LTC_DWIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]        fcnt_r, fcnt_s;
    logic [LTC_AWIDTH-1:0] addr_r;
    logic                  awvalid_r, busy_r, done_r, err_r;
    logic                  start_s, zero_start_s, take_s, last_s;
    logic                  rq_vld_s, push_s, pop_s, full_s, drop_s, wr_en_s, fin_s;
    logic [7:0]            rq_q_s;

    assign elem_s = drain_elem_t'(i_dat);

    aixh_mxc_drain_requant #(
        .ACC_W (ACCUM_BITS),
        .SCL_W (SCALE_BITS)
    ) u_requant (
        .clk      (aixh_core_clk2x),
        .rstn     (aixh_core_rstn),
        .shift    (shift_r),
        .relu     (relu_r),
        .in_vld   (take_s),
        .in_acc   (elem_s.acc),
        .in_scale (elem_s.scale),
        .out_vld  (rq_vld_s),
        .out_q    (rq_q_s)
    );

    // Job control, FIFO push/pop decisions and completion; dropped words still count.
    always_comb begin
        start_s      = (state_r == IDLE) && cfg_start && (cfg_words != 16'd0);
        zero_start_s = (state_r == IDLE) && cfg_start && (cfg_words == 16'd0);
        take_s       = i_vld && (state_r == RUN);
        elem_inc_s   = elem_cnt_r + ECNT_W'(1);
        quota_s      = {1'b0, words_r, {LANE_W{1'b0}}};
        last_s       = take_s && (elem_inc_s == quota_s);
        push_s       = rq_vld_s && (lane_r == LANE_W'(LANES - 1));
        push_word_s  = {rq_q_s, word_r[LTC_DWIDTH-9:0]};
        pop_s        = awvalid_r && ltc_awupdate;
        full_s       = (fcnt_r == (PTR_W+1)'(FIFO_DEPTH));
        drop_s       = push_s && full_s && !pop_s;
        wr_en_s      = push_s && !drop_s;
        fin_s        = (state_r == DRAIN) && (pop_s || drop_s) &&
                       ((done_cnt_r + 16'd1) == words_r);
        fcnt_s       = fcnt_r;
        case ({wr_en_s, pop_s})
            2'b10:   fcnt_s = fcnt_r + (PTR_W+1)'(1);
            2'b01:   fcnt_s = fcnt_r - (PTR_W+1)'(1);
            default: fcnt_s = fcnt_r;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_s = RUN;
                else         state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DRAIN;
                else        state_s = RUN;
            end
            DRAIN: begin
                if (fin_s) state_s = IDLE;
                else       state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, job registers, lane packing and status outputs.
    always_ff @(posedge aixh_core_clk2x) begin
        if (!aixh_core_rstn) begin
            state_r    <= IDLE;
            words_r    <= 16'd0;
            shift_r    <= 6'd0;
            relu_r     <= 1'b0;
            elem_cnt_r <= '0;
            done_cnt_r <= 16'd0;
            lane_r     <= '0;
            word_r     <= '0;
            addr_r     <= '0;
            awvalid_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= zero_start_s || fin_s;
            err_r     <= err_r || drop_s || (i_vld && (state_r != RUN));
            awvalid_r <= (fcnt_s != (PTR_W+1)'(0));
            if (start_s) begin
                words_r    <= cfg_words;
                shift_r    <= cfg_shift;
                relu_r     <= cfg_relu;
                elem_cnt_r <= '0;
                done_cnt_r <= 16'd0;
                lane_r     <= '0;
                addr_r     <= cfg_base;
            end else begin
                if (take_s)          elem_cnt_r <= elem_inc_s;
                if (pop_s || drop_s) done_cnt_r <= done_cnt_r + 16'd1;
                if (pop_s)           addr_r     <= addr_r + LTC_AWIDTH'(1);
                if (rq_vld_s)        lane_r     <= lane_r + LANE_W'(1);
            end
            if (rq_vld_s) word_r[{lane_r, 3'b000} +: 8] <= rq_q_s;
        end
    end

    // Packed-word FIFO; simultaneous push and pop are both honoured even when full.
    always_ff @(posedge aixh_core_clk2x) begin
        if (!aixh_core_rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fcnt_r   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            fcnt_r <= fcnt_s;
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_word_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
    end

    assign ltc_awvalid = awvalid_r;
    assign ltc_awaddr  = addr_r;
    assign ltc_wdata   = mem_r[rd_ptr_r];
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_err       = err_r;

endmodule

// File: tb/tb_aixh_mxc_drain_packer.sv
// Directed self-checking bench for aixh_mxc_drain_packer (default parameters, LANES=32).
`timescale 1ns/1ps
module tb_aixh_mxc_drain_packer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cfg_start;
    logic [15:0]  cfg_base;
    logic [15:0]  cfg_words;
    logic [5:0]   cfg_shift;
    logic         cfg_relu;
    logic         i_vld;
    logic [63:0]  i_dat;
    logic         ltc_awvalid;
    logic [15:0]  ltc_awaddr;
    logic [255:0] ltc_wdata;
    logic         ltc_awupdate;
    logic         o_busy;
    logic         o_done;
    logic         o_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aixh_mxc_drain_packer dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rstn  (rstn),
        .cfg_start       (cfg_start),
        .cfg_base        (cfg_base),
        .cfg_words       (cfg_words),
        .cfg_shift       (cfg_shift),
        .cfg_relu        (cfg_relu),
        .i_vld           (i_vld),
        .i_dat           (i_dat),
        .ltc_awvalid     (ltc_awvalid),
        .ltc_awaddr      (ltc_awaddr),
        .ltc_wdata       (ltc_wdata),
        .ltc_awupdate    (ltc_awupdate),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input longint acc, input int scl);
        logic [63:0] a;
        logic [31:0] s;
        a = acc;
        s = scl;
        return {s[15:0], a[47:0]};
    endfunction

    task automatic do_reset();
        rstn = 1'b0; cfg_start = 1'b0; i_vld = 1'b0; i_dat = 64'd0; ltc_awupdate = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic start_job(input logic [15:0] base, input logic [15:0] words,
                             input logic [5:0] sh, input logic relu);
        cfg_base = base; cfg_words = words; cfg_shift = sh; cfg_relu = relu;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_alt(input int n, input longint ae, input int se, input longint ao, input int so);
        for (int i = 0; i < n; i++) begin
            i_vld = 1'b1;
            i_dat = (i % 2 == 0) ? mk(ae, se) : mk(ao, so);
            tick();
        end
        i_vld = 1'b0;
    endtask

    task automatic wait_awvalid(output bit ok);
        for (int k = 0; k < 20 && !ltc_awvalid; k++) tick();
        ok = ltc_awvalid;
    endtask

    task automatic test_reset();
        rstn = 1'b0; cfg_start = 1'b0; cfg_base = 16'd0; cfg_words = 16'd0; cfg_shift = 6'd0;
        cfg_relu = 1'b0; i_vld = 1'b0; i_dat = 64'd0; ltc_awupdate = 1'b0;
        tick(); tick();
        n_cmp++; if (ltc_awvalid !== 1'b0) begin n_bad++; $display("FAIL reset_awvalid: got %b want 0", ltc_awvalid); end
        n_cmp++; if (ltc_awaddr !== 16'h0000) begin n_bad++; $display("FAIL reset_awaddr: got %h want 0000", ltc_awaddr); end
        n_cmp++; if (ltc_wdata !== 256'd0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", ltc_wdata); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_err); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_zero_words();
        start_job(16'h0040, 16'd0, 6'd0, 1'b0);
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", o_done); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", o_busy); end
        tick();
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", o_done); end
        n_cmp++; if (ltc_awvalid !== 1'b0) begin n_bad++; $display("FAIL zero_awvalid: got %b want 0", ltc_awvalid); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] w0, w1;
        logic         av;
        w0 = {16{16'hFB28}};
        w1 = {16{16'h807F}};
        ltc_awupdate = 1'b1;
        start_job(16'h0100, 16'd2, 6'd0, 1'b0);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", o_busy); end
        for (int i = 0; i < 64; i++) begin
            i_vld = 1'b1;
            if (i < 32) i_dat = (i % 2 == 0) ? mk(40, 1) : mk(-5, 1);
            else        i_dat = (i % 2 == 0) ? mk(200, 1) : mk(-300, 1);
            tick();
            av = ltc_awvalid;
            if (i >= 31 && i <= 33) begin
                n_cmp++; if (av !== 1'b0) begin n_bad++; $display("FAIL b2b_early_awvalid[%0d]: got %b want 0", i, av); end
            end
            if (i == 34) begin
                n_cmp++; if (av !== 1'b1) begin n_bad++; $display("FAIL b2b_first_awvalid: got %b want 1", av); end
                n_cmp++; if (ltc_awaddr !== 16'h0100) begin n_bad++; $display("FAIL b2b_addr0: got %h want 0100", ltc_awaddr); end
                n_cmp++; if (ltc_wdata !== w0) begin n_bad++; $display("FAIL b2b_data0: got %h want %h", ltc_wdata, w0); end
            end
        end
        i_vld = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (ltc_awvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_awvalid1: got %b want 1", ltc_awvalid); end
        n_cmp++; if (ltc_awaddr !== 16'h0101) begin n_bad++; $display("FAIL b2b_addr1: got %h want 0101", ltc_awaddr); end
        n_cmp++; if (ltc_wdata !== w1) begin n_bad++; $display("FAIL b2b_data1: got %h want %h", ltc_wdata, w1); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_early: got %b want 0", o_done); end
        tick();
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", o_done); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b want 0", o_busy); end
        tick();
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse: got %b want 0", o_done); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err: got %b want 0", o_err); end
    endtask

    task automatic test_requant();
        int           sh [3] = '{4, 1, 1};
        bit           rl [3] = '{1'b0, 1'b0, 1'b1};
        longint       ae [3] = '{1000, -100, -100};
        int           se [3] = '{3, 2, 2};
        longint       ao [3] = '{40, 100, 100};
        int           so [3] = '{2, 1, 1};
        logic [15:0]  ch [3] = '{16'h057F, 16'h329C, 16'h3200};
        logic [255:0] expw;
        bit           ok;
        ltc_awupdate = 1'b1;
        for (int j = 0; j < 3; j++) begin
            expw = {16{ch[j]}};
            start_job(16'h0010, 16'd1, sh[j][5:0], rl[j]);
            send_alt(32, ae[j], se[j], ao[j], so[j]);
            wait_awvalid(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rq_timeout[%0d]: got awvalid 0 want 1", j); end
            n_cmp++; if (ltc_wdata !== expw) begin n_bad++; $display("FAIL rq_data[%0d]: got %h want %h", j, ltc_wdata, expw); end
            tick();
            n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL rq_done[%0d]: got %b want 1", j, o_done); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] expw;
        logic [7:0]   v;
        ltc_awupdate = 1'b0;
        start_job(16'h0200, 16'd6, 6'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            for (int l = 0; l < 32; l++) begin
                i_vld = 1'b1;
                i_dat = mk(k + 1, 1);
                tick();
            end
        end
        i_vld = 1'b0;
        repeat (5) tick();
        expw = {32{8'h01}};
        n_cmp++; if (ltc_awvalid !== 1'b1) begin n_bad++; $display("FAIL bp_awvalid: got %b want 1", ltc_awvalid); end
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL bp_err: got %b want 1", o_err); end
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", o_busy); end
        repeat (10) tick();
        n_cmp++; if (ltc_awaddr !== 16'h0200) begin n_bad++; $display("FAIL bp_hold_addr: got %h want 0200", ltc_awaddr); end
        n_cmp++; if (ltc_wdata !== expw) begin n_bad++; $display("FAIL bp_hold_data: got %h want %h", ltc_wdata, expw); end
        ltc_awupdate = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = 8'(k + 1);
            expw = {32{v}};
            n_cmp++; if (ltc_awaddr !== 16'h0200 + 16'(k)) begin n_bad++; $display("FAIL bp_addr[%0d]: got %h want %h", k, ltc_awaddr, 16'h0200 + 16'(k)); end
            n_cmp++; if (ltc_wdata !== expw) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", k, ltc_wdata, expw); end
            tick();
        end
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", o_done); end
        n_cmp++; if (ltc_awvalid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", ltc_awvalid); end
    endtask

    task automatic test_addr_wrap();
        logic [255:0] expw;
        expw = {16{16'h0201}};
        ltc_awupdate = 1'b0;
        start_job(16'hFFFF, 16'd2, 6'd0, 1'b0);
        send_alt(64, 1, 1, 2, 1);
        repeat (4) tick();
        n_cmp++; if (ltc_awaddr !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_addr0: got %h want ffff", ltc_awaddr); end
        ltc_awupdate = 1'b1;
        tick();
        n_cmp++; if (ltc_awvalid !== 1'b1) begin n_bad++; $display("FAIL wrap_awvalid1: got %b want 1", ltc_awvalid); end
        n_cmp++; if (ltc_awaddr !== 16'h0000) begin n_bad++; $display("FAIL wrap_addr1: got %h want 0000", ltc_awaddr); end
        n_cmp++; if (ltc_wdata !== expw) begin n_bad++; $display("FAIL wrap_data1: got %h want %h", ltc_wdata, expw); end
        tick();
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", o_done); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b want 0", o_err); end
    endtask

    task automatic test_idle_vld();
        i_vld = 1'b1;
        i_dat = mk(5, 1);
        tick();
        i_vld = 1'b0;
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL idle_err: got %b want 1", o_err); end
        repeat (5) tick();
        n_cmp++; if (ltc_awvalid !== 1'b0) begin n_bad++; $display("FAIL idle_nowrite: got %b want 0", ltc_awvalid); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid_drain();
        logic [255:0] expw;
        bit           ok;
        do_reset();
        ltc_awupdate = 1'b0;
        start_job(16'h0080, 16'd2, 6'd0, 1'b0);
        send_alt(64, 9, 1, 9, 1);
        repeat (4) tick();
        n_cmp++; if (ltc_awvalid !== 1'b1) begin n_bad++; $display("FAIL mid_awvalid: got %b want 1", ltc_awvalid); end
        rstn = 1'b0;
        tick();
        n_cmp++; if (ltc_awvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_awvalid: got %b want 0", ltc_awvalid); end
        n_cmp++; if (ltc_awaddr !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_addr: got %h want 0000", ltc_awaddr); end
        n_cmp++; if (ltc_wdata !== 256'd0) begin n_bad++; $display("FAIL mid_rst_wdata: got %h want 0", ltc_wdata); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
        rstn = 1'b1;
        ltc_awupdate = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL mid_no_done[%0d]: got %b want 0", k, o_done); end
        end
        expw = {32{8'h07}};
        start_job(16'h0300, 16'd1, 6'd0, 1'b0);
        send_alt(32, 7, 1, 7, 1);
        wait_awvalid(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL clean_timeout: got awvalid 0 want 1"); end
        n_cmp++; if (ltc_awaddr !== 16'h0300) begin n_bad++; $display("FAIL clean_addr: got %h want 0300", ltc_awaddr); end
        n_cmp++; if (ltc_wdata !== expw) begin n_bad++; $display("FAIL clean_data: got %h want %h", ltc_wdata, expw); end
        tick();
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL clean_done: got %b want 1", o_done); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL clean_err: got %b want 0", o_err); end
    endtask

    initial begin
        test_reset();
        test_zero_words();
        test_back_to_back();
        test_requant();
        test_backpressure();
        do_reset();
        test_addr_wrap();
        test_idle_vld();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
